idu_pipe: RTL and testbench
===========================

IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width; 2**REG_AW registers.
REQ-003 SHALL have parameter NUM_FWD, default 3, forwarding sources; index 0 is the youngest.
REQ-004 SHALL have one clock; reset is asynchronous and active-high (brq_clk, brq_rst).
REQ-005 brq_clk  in  1  clock.
REQ-006 brq_rst  in  1  asynchronous active-high reset.
REQ-007 ifu_valid  in  1  fetch holds a valid instruction.
REQ-008 ifu_ready  out  1  decode accepts this cycle.
REQ-009 ifu_inst, ifu_pc  in  DATA_W each  RV32I instruction and its PC.
REQ-010 fwd_en, fwd_is_load  in  NUM_FWD  later stage writes rd; the data is not yet available (load).
REQ-011 fwd_addr  in  NUM_FWD*REG_AW; fwd_data  in  NUM_FWD*DATA_W  rd and result of each later stage.
REQ-012 wb_en  in  1; wb_addr  in  REG_AW; wb_data  in  DATA_W  register-file write port.
REQ-013 flush_in  in  1  kill from a later stage.
REQ-014 ex_ready  in  1  downstream accepts.
REQ-015 idu_valid  out  1; idu_pc, idu_rs1_data, idu_rs2_data, idu_imm  out  DATA_W; idu_rd  out  REG_AW; idu_rf_wen  out  1; idu_func3  out  3; idu_func7  out  7.
REQ-016 idu_redirect  out  1; idu_redirect_pc  out  DATA_W  combinational PC redirect to fetch.
REQ-017 stall_cnt  out  32  count of load-use interlock cycles.

Function
REQ-018 Register file: x0 SHALL read 0 and ignore writes; the write takes effect at the clock edge.
REQ-019 Operand select, in priority order: x0 -> 0; lowest index i with fwd_en[i], !fwd_is_load[i] and address match -> fwd_data[i]; wb_en with address match -> wb_data; otherwise the register file.
REQ-020 hazard SHALL be 1 when a used rs (per opcode) matches any fwd_en[i] & fwd_is_load[i] entry with a nonzero address.
REQ-021 ifu_ready = !hazard & !flush_in & (!idu_valid | ex_ready).
REQ-022 Accept = ifu_valid & ifu_ready; on accept, all idu_* fields SHALL load at the next edge and idu_valid SHALL become 1 (one-cycle latency).
REQ-023 When idu_valid & !ex_ready, all idu_* outputs SHALL hold stable.
REQ-024 When idu_valid & ex_ready & no accept, idu_valid SHALL clear at the next edge.
REQ-025 flush_in SHALL clear idu_valid at the next edge and block accept; flush wins over a simultaneous accept.
REQ-026 Immediates: I for OP-IMM/LOAD/JALR, S for STORE, U for LUI/AUIPC, J for JAL, B for BRANCH; all sign-extended to DATA_W; 0 otherwise.
REQ-027 idu_rf_wen SHALL be 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR with rd!=0; otherwise 0.
REQ-028 idu_redirect SHALL be asserted only on accept of a taken transfer:
- JAL -> pc+Jimm
- JALR -> (rs1+Iimm) & ~1
- BRANCH taken per func3 (BEQ/BNE/BLT/BGE/BLTU/BGEU, forwarded operands) -> pc+Bimm.
REQ-029 Redirect SHALL be 0 while hazard or flush_in is 1; the redirecting instruction still issues.
REQ-030 stall_cnt SHALL increment on each cycle with ifu_valid & hazard, and saturate at 2**32-1.
REQ-031 Arithmetic is modulo 2**DATA_W; PC wrap-around is not trapped.

Reset
REQ-032 brq_rst SHALL asynchronously clear the following to 0: idu_valid, all idu_* outputs, stall_cnt, and all registers.
REQ-033 Combinational outputs (ifu_ready, idu_redirect, idu_redirect_pc) follow their equations during reset; ifu_ready is forced 0 while brq_rst=1.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction; no accept occurs in the first cycle after release unless ifu_valid=1.

Verification
REQ-035 Write x5=0x1234 via wb, then decode ADDI x6,x5,1 with no forwarding -> idu_rs1_data=0x1234, idu_imm=1, idu_rd=6, idu_rf_wen=1 one cycle after accept.
REQ-036 fwd_en[0]=fwd_en[2]=1, both with addr 7, data 0xA and 0xB; decode ADD x1,x7,x0 -> idu_rs1_data=0xA, idu_rs2_data=0.
REQ-037 fwd_is_load[1]=1 with addr 3; decode SW x3,0(x2) held for 2 cycles -> ifu_ready=0 both cycles, stall_cnt=2, accept in the cycle the load clears.
REQ-038 BEQ x1,x2,+16 at pc 0x100 with x1=x2=5 -> idu_redirect=1, idu_redirect_pc=0x110; with x2=6 -> idu_redirect=0.
REQ-039 ex_ready=0 for 3 cycles with idu_valid=1 -> outputs unchanged and ifu_ready=0; flush_in pulse on the same cycle as ifu_valid -> idu_valid=0 next cycle and no accept.
REQ-040 Assert brq_rst asynchronously mid-cycle while idu_valid=1 -> idu_valid=0 and stall_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/idu_pipe.sv
// RV32I decode stage: register file, operand forwarding, load-use interlock,
// early branch/jump redirect and a single valid/ready output register.
module idu_opsel #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic                      used,
  input  logic [DATA_W-1:0]         rf_val,
  input  logic [NUM_FWD-1:0]        fwd_en,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      wb_en,
  input  logic [REG_AW-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [DATA_W-1:0]         data,
  output logic                      hazard
);
  always_comb begin
    data = rf_val;
    if (wb_en && wb_addr == rs) data = wb_data;
    // walk oldest to youngest so the lowest matching index wins
    for (int i = NUM_FWD-1; i >= 0; i--)
      if (fwd_en[i] && !fwd_is_load[i] && fwd_addr[i*REG_AW +: REG_AW] == rs)
        data = fwd_data[i*DATA_W +: DATA_W];
    if (rs == '0) data = '0;
    hazard = 1'b0;
    for (int i = 0; i < NUM_FWD; i++)
      if (used && fwd_en[i] && fwd_is_load[i] && fwd_addr[i*REG_AW +: REG_AW] != '0 &&
          fwd_addr[i*REG_AW +: REG_AW] == rs)
        hazard = 1'b1;
  end
endmodule

module idu_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3
) (
  input  logic                      brq_clk,
  input  logic                      brq_rst,
  input  logic                      ifu_valid,
  output logic                      ifu_ready,
  input  logic [DATA_W-1:0]         ifu_inst,
  input  logic [DATA_W-1:0]         ifu_pc,
  input  logic [NUM_FWD-1:0]        fwd_en,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      wb_en,
  input  logic [REG_AW-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      flush_in,
  input  logic                      ex_ready,
  output logic                      idu_valid,
  output logic [DATA_W-1:0]         idu_pc,
  output logic [DATA_W-1:0]         idu_rs1_data,
  output logic [DATA_W-1:0]         idu_rs2_data,
  output logic [DATA_W-1:0]         idu_imm,
  output logic [REG_AW-1:0]         idu_rd,
  output logic                      idu_rf_wen,
  output logic [2:0]                idu_func3,
  output logic [6:0]                idu_func7,
  output logic                      idu_redirect,
  output logic [DATA_W-1:0]         idu_redirect_pc,
  output logic [31:0]               stall_cnt
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic [DATA_W-1:0]            rf [2**REG_AW];
  logic [31:0]                  ins;
  logic [6:0]                   opcode;
  logic [REG_AW-1:0]            rd;
  logic [1:0][REG_AW-1:0]       rs;
  logic [1:0]                   used, hz;
  logic [1:0][DATA_W-1:0]       rf_val, opnd;
  logic [31:0]                  imm32;
  logic [DATA_W-1:0]            imm, target, jalr_sum;
  logic                         wen_op, taken, hazard, accept;

  assign ins    = ifu_inst[31:0];
  assign opcode = ins[6:0];
  assign rd     = REG_AW'(ins[11:7]);
  assign rs[0]  = REG_AW'(ins[19:15]);
  assign rs[1]  = REG_AW'(ins[24:20]);

  for (genvar g = 0; g < 2; g++) begin : g_op
    assign rf_val[g] = rf[rs[g]];
    idu_opsel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_opsel (
      .rs(rs[g]), .used(used[g]), .rf_val(rf_val[g]),
      .fwd_en(fwd_en), .fwd_is_load(fwd_is_load), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .data(opnd[g]), .hazard(hz[g]));
  end

  assign hazard   = |hz;
  assign imm      = DATA_W'($signed(imm32));
  assign jalr_sum = opnd[0] + imm;

  always_comb begin
    imm32  = '0;
    used   = 2'b00;
    wen_op = 1'b0;
    taken  = 1'b0;
    target = ifu_pc + imm;
    case (opcode)
      OP_R:     begin used = 2'b11; wen_op = 1'b1; end
      OP_I, OP_LD: begin
        used = 2'b01; wen_op = 1'b1; imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_ST:    begin used = 2'b11; imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      OP_LUI, OP_AUIPC: begin wen_op = 1'b1; imm32 = {ins[31:12], 12'b0}; end
      OP_JAL: begin
        wen_op = 1'b1; taken = 1'b1;
        imm32  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_JALR: begin
        used = 2'b01; wen_op = 1'b1; taken = 1'b1;
        imm32  = {{20{ins[31]}}, ins[31:20]};
        target = {jalr_sum[DATA_W-1:1], 1'b0};
      end
      OP_BR: begin
        used  = 2'b11;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        case (ins[14:12])
          3'b000:  taken = opnd[0] == opnd[1];
          3'b001:  taken = opnd[0] != opnd[1];
          3'b100:  taken = $signed(opnd[0]) <  $signed(opnd[1]);
          3'b101:  taken = $signed(opnd[0]) >= $signed(opnd[1]);
          3'b110:  taken = opnd[0] <  opnd[1];
          3'b111:  taken = opnd[0] >= opnd[1];
          default: taken = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign ifu_ready       = !brq_rst && !hazard && !flush_in && (!idu_valid || ex_ready);
  assign accept          = ifu_valid && ifu_ready;
  assign idu_redirect    = accept && taken;
  assign idu_redirect_pc = target;

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      idu_valid    <= 1'b0;
      idu_pc       <= '0;
      idu_rs1_data <= '0;
      idu_rs2_data <= '0;
      idu_imm      <= '0;
      idu_rd       <= '0;
      idu_rf_wen   <= 1'b0;
      idu_func3    <= '0;
      idu_func7    <= '0;
      stall_cnt    <= '0;
    end else begin
      if (flush_in) begin
        idu_valid <= 1'b0;
      end else if (accept) begin
        idu_valid    <= 1'b1;
        idu_pc       <= ifu_pc;
        idu_rs1_data <= opnd[0];
        idu_rs2_data <= opnd[1];
        idu_imm      <= imm;
        idu_rd       <= rd;
        idu_rf_wen   <= wen_op && rd != '0;
        idu_func3    <= ins[14:12];
        idu_func7    <= ins[31:25];
      end else if (ex_ready) begin
        idu_valid <= 1'b0;
      end
      if (ifu_valid && hazard && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: directed scenarios plus a randomized run against a
// spec-level decode/operand/hazard model.
module tb_idu_pipe;
  localparam int DW = 32, AW = 5, NF = 3;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_SYS = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        wen;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  logic brq_clk = 1'b0, brq_rst;
  logic ifu_valid, ifu_ready, wb_en, flush_in, ex_ready;
  logic [DW-1:0] ifu_inst, ifu_pc, wb_data;
  logic [NF-1:0] fwd_en, fwd_is_load;
  logic [NF*AW-1:0] fwd_addr;
  logic [NF*DW-1:0] fwd_data;
  logic [AW-1:0] wb_addr;
  logic idu_valid, idu_rf_wen, idu_redirect;
  logic [DW-1:0] idu_pc, idu_rs1_data, idu_rs2_data, idu_imm, idu_redirect_pc;
  logic [AW-1:0] idu_rd;
  logic [2:0] idu_func3;
  logic [6:0] idu_func7;
  logic [31:0] stall_cnt;

  int n_tests = 0, n_fail = 0;
  logic [31:0] mrf [32];

  always #5 brq_clk = ~brq_clk;

  idu_pipe #(.DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF)) dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .ifu_inst(ifu_inst), .ifu_pc(ifu_pc), .fwd_en(fwd_en), .fwd_is_load(fwd_is_load),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush_in(flush_in), .ex_ready(ex_ready), .idu_valid(idu_valid),
    .idu_pc(idu_pc), .idu_rs1_data(idu_rs1_data), .idu_rs2_data(idu_rs2_data),
    .idu_imm(idu_imm), .idu_rd(idu_rd), .idu_rf_wen(idu_rf_wen), .idu_func3(idu_func3),
    .idu_func7(idu_func7), .idu_redirect(idu_redirect), .idu_redirect_pc(idu_redirect_pc),
    .stall_cnt(stall_cnt));

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(logic [6:0] op, int rd, int rs1, int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'd0, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), OP_R};
  endfunction
  function automatic logic [31:0] enc_s(int rs1, int rs2, int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'd2, im[4:0], OP_ST};
  endfunction
  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], OP_BR};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_opnd(int r);
    if (r == 0) return 32'd0;
    for (int i = 0; i < NF; i++)
      if (fwd_en[i] && !fwd_is_load[i] && int'(fwd_addr[i*AW +: AW]) == r)
        return fwd_data[i*DW +: DW];
    if (wb_en && int'(wb_addr) == r) return wb_data;
    return mrf[r];
  endfunction

  function automatic logic [31:0] m_imm(logic [31:0] n);
    logic signed [31:0] v;
    v = 0;
    case (n[6:0])
      OP_I, OP_LD, OP_JALR: v = $signed(n[31:20]);
      OP_ST:   v = $signed({n[31:25], n[11:7]});
      OP_LUI, OP_AUIPC: v = n[31:12] * 32'd4096;
      OP_JAL:  v = $signed({n[31], n[19:12], n[20], n[30:21], 1'b0});
      OP_BR:   v = $signed({n[31], n[7], n[30:25], n[11:8], 1'b0});
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic m_hazard(logic [31:0] n);
    logic u1, u2;
    u1 = n[6:0] inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR};
    u2 = n[6:0] inside {OP_R, OP_ST, OP_BR};
    for (int i = 0; i < NF; i++)
      if (fwd_en[i] && fwd_is_load[i] && fwd_addr[i*AW +: AW] != 0 &&
          ((u1 && fwd_addr[i*AW +: AW] == n[19:15]) || (u2 && fwd_addr[i*AW +: AW] == n[24:20])))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_xfer(logic [31:0] n, logic [31:0] pc, logic [31:0] a, logic [31:0] b,
                                 output logic tk, output logic [31:0] tgt);
    logic [31:0] im;
    im = m_imm(n);
    tk = 1'b0;
    tgt = pc + im;
    case (n[6:0])
      OP_JAL:  tk = 1'b1;
      OP_JALR: begin tk = 1'b1; tgt = (a + im) & 32'hFFFF_FFFE; end
      OP_BR:
        case (n[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
      default: ;
    endcase
  endfunction

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge brq_clk); #1;
  endtask

  task automatic idle();
    ifu_valid = 0; ifu_inst = 0; ifu_pc = 0; fwd_en = 0; fwd_is_load = 0; fwd_addr = 0;
    fwd_data = 0; wb_en = 0; wb_addr = 0; wb_data = 0; flush_in = 0; ex_ready = 1;
  endtask

  task automatic wb_write(int a, logic [31:0] d);
    wb_en = 1; wb_addr = AW'(a); wb_data = d;
    tick();
    if (a != 0) mrf[a] = d;
    wb_en = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    brq_rst = 1;
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    #3;
    n_tests++;
    if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ifu_ready); end
    tick(); tick();
    n_tests++;
    if ({idu_valid, stall_cnt, idu_pc, idu_rs1_data, idu_rs2_data, idu_imm, idu_rd, idu_rf_wen,
         idu_func3, idu_func7} !== '0) begin
      n_fail++; $display("FAIL reset_state: valid=%b stall=%h pc=%h imm=%h", idu_valid, stall_cnt, idu_pc, idu_imm);
    end
    brq_rst = 0;
    tick();
  endtask

  task automatic test_wb_operand();
    wb_write(5, 32'h1234);
    ifu_valid = 1; ifu_pc = 32'h40; ifu_inst = enc_i(OP_I, 6, 5, 1);
    #4;
    n_tests++;
    if (ifu_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready: got %b want 1", ifu_ready); end
    tick();
    ifu_valid = 0;
    n_tests++;
    if ({idu_valid, idu_rs1_data, idu_imm, idu_rd, idu_rf_wen, idu_pc} !==
        {1'b1, 32'h1234, 32'd1, 5'd6, 1'b1, 32'h40}) begin
      n_fail++;
      $display("FAIL addi_fields: valid=%b rs1=%h imm=%h rd=%0d wen=%b pc=%h want 1/1234/1/6/1/40",
               idu_valid, idu_rs1_data, idu_imm, idu_rd, idu_rf_wen, idu_pc);
    end
  endtask

  task automatic test_fwd_priority();
    wb_en = 1; wb_addr = 7; wb_data = 32'hC;
    fwd_en = 3'b111; fwd_is_load = 0;
    fwd_addr = {5'd7, 5'd0, 5'd7};
    fwd_data = {32'hB, 32'hDEAD, 32'hA};
    ifu_valid = 1; ifu_pc = 32'h44; ifu_inst = enc_r(1, 7, 0);
    tick();
    mrf[7] = 32'hC;
    idle();
    n_tests++;
    if ({idu_valid, idu_rs1_data, idu_rs2_data, idu_rd} !== {1'b1, 32'hA, 32'h0, 5'd1}) begin
      n_fail++;
      $display("FAIL fwd_priority: valid=%b rs1=%h rs2=%h rd=%0d want 1/a/0/1",
               idu_valid, idu_rs1_data, idu_rs2_data, idu_rd);
    end
  endtask

  task automatic test_load_use();
    fwd_en = 3'b010; fwd_is_load = 3'b010; fwd_addr = {5'd0, 5'd3, 5'd0};
    ifu_valid = 1; ifu_pc = 32'h48; ifu_inst = enc_s(2, 3, 0);
    for (int c = 0; c < 2; c++) begin
      #4;
      n_tests++;
      if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_ready%0d: got %b want 0", c, ifu_ready); end
      tick();
    end
    n_tests++;
    if ({stall_cnt, idu_valid} !== {32'd2, 1'b0}) begin
      n_fail++; $display("FAIL load_use_stall: cnt=%0d valid=%b want 2/0", stall_cnt, idu_valid);
    end
    fwd_en = 0; fwd_is_load = 0;
    #4;
    n_tests++;
    if (ifu_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_release: got %b want 1", ifu_ready); end
    tick();
    ifu_valid = 0;
    n_tests++;
    if ({idu_valid, idu_pc, idu_rf_wen, idu_func3, stall_cnt} !== {1'b1, 32'h48, 1'b0, 3'd2, 32'd2}) begin
      n_fail++;
      $display("FAIL load_use_issue: valid=%b pc=%h wen=%b f3=%0d cnt=%0d want 1/48/0/2/2",
               idu_valid, idu_pc, idu_rf_wen, idu_func3, stall_cnt);
    end
  endtask

  task automatic test_branch();
    wb_write(1, 5);
    wb_write(2, 5);
    ifu_valid = 1; ifu_pc = 32'h100; ifu_inst = enc_b(0, 1, 2, 16);
    #4;
    n_tests++;
    if ({idu_redirect, idu_redirect_pc} !== {1'b1, 32'h110}) begin
      n_fail++; $display("FAIL beq_taken: redir=%b pc=%h want 1/110", idu_redirect, idu_redirect_pc);
    end
    tick();
    ifu_valid = 0;
    wb_write(2, 6);
    ifu_valid = 1;
    #4;
    n_tests++;
    if ({idu_redirect, ifu_ready} !== 2'b01) begin
      n_fail++; $display("FAIL beq_not_taken: redir=%b ready=%b want 0/1", idu_redirect, ifu_ready);
    end
    tick();
    ifu_valid = 0;
    tick();
  endtask

  task automatic test_stall_flush();
    ifu_valid = 1; ifu_pc = 32'h200; ifu_inst = enc_i(OP_I, 6, 5, 1);
    tick();
    ex_ready = 0; ifu_pc = 32'h204; ifu_inst = enc_r(3, 1, 2);
    for (int c = 0; c < 3; c++) begin
      #4;
      n_tests++;
      if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready%0d: got %b want 0", c, ifu_ready); end
      tick();
      n_tests++;
      if ({idu_valid, idu_pc, idu_rs1_data, idu_imm, idu_rd, idu_rf_wen} !==
          {1'b1, 32'h200, 32'h1234, 32'd1, 5'd6, 1'b1}) begin
        n_fail++;
        $display("FAIL hold_fields%0d: valid=%b pc=%h rs1=%h imm=%h rd=%0d want 1/200/1234/1/6",
                 c, idu_valid, idu_pc, idu_rs1_data, idu_imm, idu_rd);
      end
    end
    flush_in = 1;
    tick();
    n_tests++;
    if (idu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_held: valid=%b want 0", idu_valid); end
    ex_ready = 1;
    #4;
    n_tests++;
    if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", ifu_ready); end
    tick();
    n_tests++;
    if (idu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: valid=%b want 0", idu_valid); end
    idle();
  endtask

  task automatic test_async_reset();
    ifu_valid = 1; ifu_pc = 32'h300; ifu_inst = enc_i(OP_I, 6, 5, 1);
    tick();
    ex_ready = 0;
    fwd_en = 3'b001; fwd_is_load = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd3};
    ifu_inst = enc_s(2, 3, 0);
    tick();
    n_tests++;
    if ({idu_valid, stall_cnt} !== {1'b1, 32'd3}) begin
      n_fail++; $display("FAIL pre_reset: valid=%b cnt=%0d want 1/3", idu_valid, stall_cnt);
    end
    #3 brq_rst = 1;
    #1;
    n_tests++;
    if ({idu_valid, stall_cnt, ifu_ready} !== {1'b0, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: valid=%b cnt=%0d ready=%b want 0/0/0", idu_valid, stall_cnt, ifu_ready);
    end
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    idle();
    tick();
    brq_rst = 0;
    tick();
    n_tests++;
    if (idu_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: valid=%b want 0", idu_valid); end
    ifu_valid = 1; ifu_pc = 32'h304; ifu_inst = enc_i(OP_I, 6, 5, 1);
    tick();
    ifu_valid = 0;
    n_tests++;
    if ({idu_valid, idu_rs1_data} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL rf_cleared: valid=%b rs1=%h want 1/0", idu_valid, idu_rs1_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    exp_t ef, got;
    logic ev, hz, rdy, acc, tk;
    logic [31:0] n, a, b, tgt;
    int es;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS};
    ev = 0; es = 0; ef = '0;
    for (int it = 0; it < 500; it++) begin
      n = $urandom;
      n[6:0] = ops[$urandom_range(0, 9)];
      n[11:7] = 5'($urandom_range(0, 7));
      n[19:15] = 5'($urandom_range(0, 7));
      n[24:20] = 5'($urandom_range(0, 7));
      ifu_inst = n; ifu_pc = $urandom; ifu_valid = ($urandom % 5) != 0;
      for (int i = 0; i < NF; i++) begin
        fwd_en[i] = $urandom % 2;
        fwd_is_load[i] = ($urandom % 4) == 0;
        fwd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        fwd_data[i*DW +: DW] = ($urandom % 2) ? $urandom : $urandom_range(0, 3);
      end
      wb_en = $urandom % 2; wb_addr = AW'($urandom_range(0, 7));
      wb_data = ($urandom % 2) ? $urandom : $urandom_range(0, 3);
      flush_in = ($urandom % 10) == 0; ex_ready = ($urandom % 4) != 0;
      #4;
      hz = m_hazard(n);
      rdy = !hz && !flush_in && (!ev || ex_ready);
      acc = ifu_valid && rdy;
      a = m_opnd(int'(n[19:15]));
      b = m_opnd(int'(n[24:20]));
      m_xfer(n, ifu_pc, a, b, tk, tgt);
      n_tests++;
      if (ifu_ready !== rdy) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", it, ifu_ready, rdy); end
      n_tests++;
      if (idu_redirect !== (acc && tk) || (acc && tk && idu_redirect_pc !== tgt)) begin
        n_fail++;
        $display("FAIL rnd_redirect[%0d]: got %b/%h want %b/%h", it, idu_redirect, idu_redirect_pc, acc && tk, tgt);
      end
      if (flush_in) ev = 0;
      else if (acc) begin
        ev = 1;
        ef = '{pc: ifu_pc, rs1: a, rs2: b, imm: m_imm(n), rd: n[11:7],
               wen: (n[6:0] inside {OP_R, OP_I, OP_LD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) && n[11:7] != 0,
               f3: n[14:12], f7: n[31:25]};
      end else if (ex_ready) ev = 0;
      if (ifu_valid && hz) es++;
      if (wb_en && wb_addr != 0) mrf[wb_addr] = wb_data;
      tick();
      n_tests++;
      if ({idu_valid, stall_cnt} !== {ev, 32'(es)}) begin
        n_fail++; $display("FAIL rnd_state[%0d]: valid=%b cnt=%0d want %b/%0d", it, idu_valid, stall_cnt, ev, es);
      end
      if (ev) begin
        got = '{pc: idu_pc, rs1: idu_rs1_data, rs2: idu_rs2_data, imm: idu_imm, rd: idu_rd,
                wen: idu_rf_wen, f3: idu_func3, f7: idu_func7};
        n_tests++;
        if (got !== ef) begin n_fail++; $display("FAIL rnd_fields[%0d]: got %h want %h", it, got, ef); end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_wb_operand();
    test_fwd_priority();
    test_load_use();
    test_branch();
    test_stall_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
